// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: MDU op codes, default latencies, FSM states and the result helper
package muldiv_unit_pkg;
  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV = 3'd2, OP_DIVU = 3'd3, OP_MTHI = 3'd4, OP_MTLO = 3'd5;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;
  localparam logic [0:0] ST_IDLE = 1'b0, ST_RUN = 1'b1;
  function automatic logic [63:0] mduResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] hiOld, input logic [31:0] loOld);
    logic [63:0] prod;
    logic [31:0] dSafe;
    logic signed [31:0] sQuo, sRem;
    logic [63:0] divRes;
    prod = op[0] ? {32'b0, a} * {32'b0, b} : $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    dSafe = (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 32'd1 : b;
    sQuo = $signed(a) / $signed(dSafe);
    sRem = $signed(a) % $signed(dSafe);
    divRes = op[0] ? {a % dSafe, a / dSafe} : {sRem, sQuo};
    return !op[1] ? prod : (b == 32'd0 ? {hiOld, loOld} : divRes);
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle mult/div responder (start/op/wen/rs/rt in; busy, architectural hi/lo out)
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        wen,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  logic [0:0] state;
  logic [CW-1:0] count;
  logic [31:0] shadowHi, shadowLo;
  logic mdStart;
  assign mdStart = start && !op[2];
  assign busy = state == ST_RUN;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
      shadowHi <= '0;
      shadowLo <= '0;
      hi <= '0;
      lo <= '0;
    end else if (state == ST_IDLE) begin
      if (mdStart) begin
        {shadowHi, shadowLo} <= mduResult(op[1:0], rs, rt, hi, lo);
        count <= op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        state <= ST_RUN;
      end else if (wen && !start) begin
        if (op == OP_MTHI) hi <= rs;
        if (op == OP_MTLO) lo <= rs;
      end
    end else begin
      count <= count - CW'(1);
      if (count == CW'(1)) begin
        hi <= shadowHi;
        lo <= shadowLo;
        state <= ST_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  logic clk = 0, reset = 1, start = 0, wen = 0;
  logic [2:0] op = 0;
  logic [31:0] rs = 0, rt = 0;
  logic busy;
  logic [31:0] hi, lo;
  muldiv_unit dut (.clk(clk), .reset(reset), .start(start), .op(op), .wen(wen), .rs(rs), .rt(rt),
                   .busy(busy), .hi(hi), .lo(lo));
  always #5 clk = ~clk;
  typedef struct {int len; logic [31:0] eHi, eLo, pHi, pLo;} exp_t;
  exp_t scb[$];
  int total = 0, bad = 0, run = 0;
  logic [31:0] mHi = 0, mLo = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sd, q, r;
    sa = longint'($signed(a));
    sd = longint'($signed(b));
    if (o == OP_MULT) return sa * sd;
    if (o == OP_MULTU) return {32'b0, a} * {32'b0, b};
    if (b == 0) return {mHi, mLo};
    if (o == OP_DIVU) return {a % b, a / b};
    q = sa / sd;
    r = sa - q * sd;
    return {r[31:0], q[31:0]};
  endfunction
  initial forever begin
    @(negedge clk);
    if (busy === 1'b1) begin
      if (scb.size() == 0) chk("busy_unexpected", 1, 0);
      else begin
        run++;
        chk("hold_hi", hi, scb[0].pHi);
        chk("hold_lo", lo, scb[0].pLo);
      end
    end else if (run > 0) begin
      exp_t e;
      e = scb.pop_front();
      chk("busy_len", run, e.len);
      chk("commit_hi", hi, e.eHi);
      chk("commit_lo", lo, e.eLo);
      run = 0;
    end
  end
  task automatic startOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [63:0] r;
    r = model(o, a, b);
    e.len = o[1] ? DIV_CYCLES_DEF : MULT_CYCLES_DEF;
    e.pHi = mHi;
    e.pLo = mLo;
    {e.eHi, e.eLo} = r;
    scb.push_back(e);
    {mHi, mLo} = r;
    start = 1; op = o; rs = a; rt = b;
    @(posedge clk); #1;
    start = 0;
  endtask
  task automatic waitIdle();
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== 1'b0) chk("idle_timeout", busy, 0);
  endtask
  task automatic doOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    startOp(o, a, b);
    waitIdle();
  endtask
  task automatic wr(input logic [2:0] o, input logic [31:0] d);
    wen = 1; op = o; rs = d;
    @(posedge clk); #1;
    wen = 0;
    if (o == OP_MTHI) mHi = d;
    if (o == OP_MTLO) mLo = d;
    chk("wr_busy", busy, 0);
    chk("wr_hi", hi, mHi);
    chk("wr_lo", lo, mLo);
  endtask
  task automatic idleCheck(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_hi"}, hi, mHi);
    chk({name, "_lo"}, lo, mLo);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    idleCheck("reset");
    doOp(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    doOp(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    doOp(OP_DIV, -32'sd7, 32'd2);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    doOp(OP_DIVU, 32'd7, 32'd2);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);
    wr(OP_MTHI, 32'h11);
    wr(OP_MTLO, 32'h22);
    doOp(OP_DIV, 32'd99, 32'd0);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);
    doOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);
    wr(OP_MTHI, 32'hDEAD_BEEF);
    chk("mthi_val", hi, 32'hDEAD_BEEF);
    wr(OP_MTLO, 32'h1234_5678);
    chk("mtlo_val", lo, 32'h1234_5678);
    startOp(OP_DIV, 32'd100, 32'd7);
    wen = 1; op = OP_MTHI; rs = 32'hAAAA_AAAA;
    @(posedge clk); #1;
    op = OP_MTLO;
    @(posedge clk); #1;
    wen = 0;
    waitIdle();
    idleCheck("wen_in_run");
    startOp(OP_DIV, 32'd1000, 32'd3);
    repeat (2) @(posedge clk);
    #1 reset = 1;
    scb[0].len = 3;
    scb[0].eHi = 0;
    scb[0].eLo = 0;
    mHi = 0; mLo = 0;
    @(posedge clk); #1 reset = 0;
    idleCheck("abort");
    startOp(OP_MULT, 32'd1234, 32'd5678);
    start = 1; op = OP_DIV; rs = 32'd50; rt = 32'd5;
    @(posedge clk); #1 start = 0;
    waitIdle();
    chk("restart_lo", lo, 32'd1234 * 32'd5678);
    start = 1; wen = 1; op = OP_MTHI; rs = 32'h5555_5555;
    @(posedge clk); #1 start = 0; wen = 0;
    idleCheck("start_wen");
    for (int i = 0; i < 40; i++) begin
      int k;
      logic [31:0] a, b;
      k = $urandom_range(0, 9);
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9)) - 32'd4 : $urandom);
      if (k < 6) doOp(3'($urandom_range(0, 3)), a, b);
      else if (k < 8) wr(k == 6 ? OP_MTHI : OP_MTLO, a);
      else begin
        start = 1; op = 3'($urandom_range(4, 7)); rs = a; rt = b;
        @(posedge clk); #1 start = 0;
        idleCheck("bad_op");
      end
    end
    repeat (3) @(posedge clk);
    chk("scb_empty", scb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
